// File: rtl/axi_bti_regs_pkg.sv
// Shared constants for the BTI sensor register bank: response codes,
// register-map offsets relative to the number of control words, CTRL0 bit positions.
package axi_bti_regs_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // CTRL0 bit that requests a channel-count snapshot; it never stores a 1
    localparam int CTRL0_CAPTURE_BIT = 1;

    function automatic int irq_status_idx(input int num_ctrl);
        return num_ctrl;
    endfunction

    function automatic int irq_enable_idx(input int num_ctrl);
        return num_ctrl + 1;
    endfunction

    function automatic int ch_count_base(input int num_ctrl);
        return num_ctrl + 2;
    endfunction

endpackage

// File: rtl/axi_bti_hold_slot.sv
// One-deep valid/ready holding register: accepts one beat while empty and
// keeps it until the consumer pops it.
module axi_bti_hold_slot #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    input  logic             i_pop,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_full <= 1'b0;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_valid && !r_full) begin
            r_data <= i_data;
        end
    end

    assign o_ready = !r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;

endmodule

// File: rtl/axi_bti_sensor_regs.sv
// AXI4-Lite register bank for the BTI sensor: control words, W1C interrupt
// status/enable, per-channel count snapshots and SLVERR on unmapped words.
module axi_bti_sensor_regs
    import axi_bti_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int NUM_CTRL_REGS      = 4,
    parameter int NUM_CH             = 4,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                                        ACLK,
    input  logic                                        ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]               S_AXI_AWADDR,
    input  logic [2:0]                                  S_AXI_AWPROT,
    input  logic                                        S_AXI_AWVALID,
    output logic                                        S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]               S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]             S_AXI_WSTRB,
    input  logic                                        S_AXI_WVALID,
    output logic                                        S_AXI_WREADY,
    output logic [1:0]                                  S_AXI_BRESP,
    output logic                                        S_AXI_BVALID,
    input  logic                                        S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]               S_AXI_ARADDR,
    input  logic [2:0]                                  S_AXI_ARPROT,
    input  logic                                        S_AXI_ARVALID,
    output logic                                        S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]               S_AXI_RDATA,
    output logic [1:0]                                  S_AXI_RRESP,
    output logic                                        S_AXI_RVALID,
    input  logic                                        S_AXI_RREADY,
    input  logic [NUM_CH*CNT_WIDTH-1:0]                 ch_count_i,
    input  logic [NUM_CH-1:0]                           ch_done_i,
    output logic [NUM_CTRL_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_o,
    output logic                                        capture_o,
    output logic                                        irq_o
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int SW       = DW / 8;
    localparam int ADDR_LSB = $clog2(DW / 8);
    localparam int IDXW     = AW - ADDR_LSB;

    localparam logic [IDXW-1:0] IDX_STATUS  = IDXW'(irq_status_idx(NUM_CTRL_REGS));
    localparam logic [IDXW-1:0] IDX_ENABLE  = IDXW'(irq_enable_idx(NUM_CTRL_REGS));
    localparam logic [IDXW-1:0] IDX_CH_BASE = IDXW'(ch_count_base(NUM_CTRL_REGS));
    localparam logic [IDXW:0]   MAP_END     = (IDXW+1)'(ch_count_base(NUM_CTRL_REGS) + NUM_CH);
    localparam logic [DW-1:0]   CTRL0_KEEP  = ~(DW'(1) << CTRL0_CAPTURE_BIT);

    if (!(DW == 32 || DW == 64)) begin : g_chk_dw
        $error("C_S_AXI_DATA_WIDTH must be 32 or 64");
    end
    if (CNT_WIDTH > DW) begin : g_chk_cnt
        $error("CNT_WIDTH must not exceed C_S_AXI_DATA_WIDTH");
    end
    if (NUM_CH < 1 || NUM_CH > DW) begin : g_chk_ch
        $error("NUM_CH must be in 1..C_S_AXI_DATA_WIDTH");
    end
    if (NUM_CTRL_REGS < 1) begin : g_chk_ctrl
        $error("NUM_CTRL_REGS must be at least 1");
    end

    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_val,
                                              input logic [DW-1:0] mask,
                                              input logic [DW-1:0] new_val);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    logic [DW-1:0]        r_ctrl [NUM_CTRL_REGS];
    logic [NUM_CH-1:0]    r_irq_status;
    logic [DW-1:0]        r_irq_enable;
    logic [CNT_WIDTH-1:0] r_chcnt [NUM_CH];
    logic                 r_bvalid;
    logic [1:0]           r_bresp;
    logic                 r_rvalid;
    logic [DW-1:0]        r_rdata;
    logic [1:0]           r_rresp;
    logic                 r_capture;
    logic                 r_irq;

    logic                 w_aw_full;
    logic                 w_w_full;
    logic [AW-1:0]        w_aw_addr;
    logic [DW+SW-1:0]     w_w_slot;
    logic [DW-1:0]        w_wdata;
    logic [SW-1:0]        w_wstrb;
    logic                 w_commit;
    logic [IDXW-1:0]      w_widx;
    logic [IDXW-1:0]      w_ridx;
    logic                 w_wr_mapped;
    logic [DW-1:0]        w_byte_mask;
    logic [DW-1:0]        w_w1c;
    logic [NUM_CH-1:0]    w_status_clr;
    logic                 w_capture;
    logic [DW-1:0]        w_status_ext;
    logic [DW-1:0]        w_rdata;
    logic [1:0]           w_rresp;
    logic                 w_unused;

    axi_bti_hold_slot #(.WIDTH(AW)) u_aw_slot (
        .i_clk   (ACLK),
        .i_rst   (ARESET),
        .i_valid (S_AXI_AWVALID),
        .i_data  (S_AXI_AWADDR),
        .o_ready (S_AXI_AWREADY),
        .i_pop   (w_commit),
        .o_full  (w_aw_full),
        .o_data  (w_aw_addr)
    );

    axi_bti_hold_slot #(.WIDTH(DW + SW)) u_w_slot (
        .i_clk   (ACLK),
        .i_rst   (ARESET),
        .i_valid (S_AXI_WVALID),
        .i_data  ({S_AXI_WSTRB, S_AXI_WDATA}),
        .o_ready (S_AXI_WREADY),
        .i_pop   (w_commit),
        .o_full  (w_w_full),
        .o_data  (w_w_slot)
    );

    assign {w_wstrb, w_wdata} = w_w_slot;
    // A held response blocks the next commit until the master takes it
    assign w_commit     = w_aw_full && w_w_full && (!r_bvalid || S_AXI_BREADY);
    assign w_widx       = w_aw_addr[AW-1:ADDR_LSB];
    assign w_ridx       = S_AXI_ARADDR[AW-1:ADDR_LSB];
    assign w_wr_mapped  = ({1'b0, w_widx} < MAP_END);
    assign w_w1c        = w_wdata & w_byte_mask;
    assign w_status_clr = (w_commit && (w_widx == IDX_STATUS)) ? w_w1c[NUM_CH-1:0] : '0;
    assign w_capture    = w_commit && (w_widx == '0) && w_w1c[CTRL0_CAPTURE_BIT];
    assign w_status_ext = DW'(r_irq_status);

    always_comb begin
        w_byte_mask = '0;
        for (int b = 0; b < SW; b++) begin
            w_byte_mask[b*8 +: 8] = {8{w_wstrb[b]}};
        end
    end

    always_comb begin
        w_rdata = '0;
        w_rresp = RESP_SLVERR;
        for (int i = 0; i < NUM_CTRL_REGS; i++) begin
            if (w_ridx == IDXW'(i)) begin
                w_rdata = r_ctrl[i];
                w_rresp = RESP_OKAY;
            end
        end
        if (w_ridx == IDX_STATUS) begin
            w_rdata = w_status_ext;
            w_rresp = RESP_OKAY;
        end
        if (w_ridx == IDX_ENABLE) begin
            w_rdata = r_irq_enable;
            w_rresp = RESP_OKAY;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ridx == IDX_CH_BASE + IDXW'(i)) begin
                w_rdata = DW'(r_chcnt[i]);
                w_rresp = RESP_OKAY;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_CTRL_REGS; i++) r_ctrl[i] <= '0;
            for (int i = 0; i < NUM_CH; i++) r_chcnt[i] <= '0;
            r_irq_status <= '0;
            r_irq_enable <= '0;
            r_bvalid     <= 1'b0;
            r_bresp      <= RESP_OKAY;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
            r_rresp      <= RESP_OKAY;
            r_capture    <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            r_capture    <= w_capture;
            r_irq        <= |(w_status_ext & r_irq_enable);
            // A done pulse wins over a simultaneous W1C of the same bit
            r_irq_status <= (r_irq_status & ~w_status_clr) | ch_done_i;

            if (w_commit) begin
                for (int i = 0; i < NUM_CTRL_REGS; i++) begin
                    if (w_widx == IDXW'(i)) begin
                        r_ctrl[i] <= f_merge(r_ctrl[i], w_byte_mask, w_wdata)
                                     & ((i == 0) ? CTRL0_KEEP : '1);
                    end
                end
                if (w_widx == IDX_ENABLE) begin
                    r_irq_enable <= f_merge(r_irq_enable, w_byte_mask, w_wdata);
                end
            end

            if (w_capture) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_chcnt[i] <= ch_count_i[i*CNT_WIDTH +: CNT_WIDTH];
                end
            end

            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end

            if (S_AXI_ARVALID && !r_rvalid) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdata;
                r_rresp  <= w_rresp;
            end else if (S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CTRL_REGS; g++) begin : g_ctrl_out
        assign ctrl_o[g*DW +: DW] = r_ctrl[g];
    end

    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = !r_rvalid;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign capture_o     = r_capture;
    assign irq_o         = r_irq;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_ARADDR[ADDR_LSB-1:0], w_aw_addr[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axi_bti_sensor_regs.sv
// Directed bench for axi_bti_sensor_regs: a write/read vector table plus
// hand-timed sequences for capture, W1C races, backpressure and reset.
module tb_axi_bti_sensor_regs;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [7:0]   S_AXI_AWADDR;
    logic [2:0]   S_AXI_AWPROT;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [7:0]   S_AXI_ARADDR;
    logic [2:0]   S_AXI_ARPROT;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [127:0] ch_count_i;
    logic [3:0]   ch_done_i;
    logic [127:0] ctrl_o;
    logic         capture_o;
    logic         irq_o;

    axi_bti_sensor_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (8),
        .NUM_CTRL_REGS      (4),
        .NUM_CH             (4),
        .CNT_WIDTH          (32)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .ch_count_i    (ch_count_i),
        .ch_done_i     (ch_done_i),
        .ctrl_o        (ctrl_o),
        .capture_o     (capture_o),
        .irq_o         (irq_o)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  bresp;
        logic [7:0]  raddr;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    vec_t        vecs [10];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [1:0]  resp;
    logic [31:0] rd;
    logic        cap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] bresp, output logic capt);
        int  n = 0;
        logic aw_hs, w_hs;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        bresp = 2'b11; capt = 1'b0;
        while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 50) begin
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            step(); n++;
            if (aw_hs) S_AXI_AWVALID = 1'b0;
            if (w_hs)  S_AXI_WVALID  = 1'b0;
        end
        S_AXI_BREADY = 1'b1;
        while (!S_AXI_BVALID && n < 50) begin step(); n++; end
        check($sformatf("wr_%0h_timeout", addr), 32'(n < 50), 32'd1);
        bresp = S_AXI_BRESP; capt = capture_o;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        step();
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] rresp);
        int n = 0;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        while (!S_AXI_ARREADY && n < 50) begin step(); n++; end
        step();
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        while (!S_AXI_RVALID && n < 50) begin step(); n++; end
        check($sformatf("rd_%0h_timeout", addr), 32'(n < 50), 32'd1);
        data = S_AXI_RDATA; rresp = S_AXI_RRESP;
        step();
        S_AXI_RREADY = 1'b0;
    endtask

    // Both write slots fill on the first edge; the commit, an optional AR
    // handshake and an optional done pulse all land on the second edge.
    task automatic write_at_commit(input logic [7:0] waddr, input logic [31:0] wdata,
                                   input logic do_rd, input logic [7:0] raddr,
                                   input logic [3:0] done, output logic [31:0] rdata);
        S_AXI_AWADDR = waddr; S_AXI_WDATA = wdata; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_ARADDR = raddr; S_AXI_ARVALID = do_rd; S_AXI_RREADY = 1'b0;
        ch_done_i = done;
        step();
        S_AXI_ARVALID = 1'b0; ch_done_i = 4'b0;
        check($sformatf("wac_%0h_bvalid", waddr), 32'(S_AXI_BVALID), 32'd1);
        rdata = S_AXI_RDATA;
        S_AXI_RREADY = 1'b1;
        step();
        S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h00, 32'h00000001, 4'hF, 2'b00, 8'h00, 32'h00000001, 2'b00};
        vecs[1] = '{8'h04, 32'hAABBCCDD, 4'hF, 2'b00, 8'h04, 32'hAABBCCDD, 2'b00};
        vecs[2] = '{8'h04, 32'h00001100, 4'h2, 2'b00, 8'h04, 32'hAABB11DD, 2'b00};
        vecs[3] = '{8'h0C, 32'h12345678, 4'hF, 2'b00, 8'h0C, 32'h12345678, 2'b00};
        vecs[4] = '{8'h08, 32'hCAFEF00D, 4'h9, 2'b00, 8'h08, 32'hCA00000D, 2'b00};
        vecs[5] = '{8'h14, 32'h0000000F, 4'hF, 2'b00, 8'h14, 32'h0000000F, 2'b00};
        vecs[6] = '{8'h10, 32'hFFFFFFFF, 4'hF, 2'b00, 8'h10, 32'h00000000, 2'b00};
        vecs[7] = '{8'h18, 32'hDEADBEEF, 4'hF, 2'b00, 8'h18, 32'h00000000, 2'b00};
        vecs[8] = '{8'hFC, 32'hFFFFFFFF, 4'hF, 2'b10, 8'hFC, 32'h00000000, 2'b10};
        vecs[9] = '{8'h28, 32'hFFFFFFFF, 4'hF, 2'b10, 8'h28, 32'h00000000, 2'b10};

        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        ch_count_i = '0; ch_done_i = '0;
        repeat (3) step();
        ARESET = 1'b0;

        // reset state
        check("rst_awready", 32'(S_AXI_AWREADY), 32'd1);
        check("rst_wready",  32'(S_AXI_WREADY),  32'd1);
        check("rst_arready", 32'(S_AXI_ARREADY), 32'd1);
        check("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
        check("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
        check("rst_rdata",   S_AXI_RDATA, 32'd0);
        check("rst_resp",    32'({S_AXI_BRESP, S_AXI_RRESP}), 32'd0);
        check("rst_cap_irq", 32'({capture_o, irq_o}), 32'd0);
        check("rst_ctrl_o",  32'(ctrl_o == '0), 32'd1);

        // AW first, W three cycles later
        S_AXI_AWADDR = 8'h00; S_AXI_AWVALID = 1'b1; S_AXI_BREADY = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0;
        check("aw_held_awready", 32'(S_AXI_AWREADY), 32'd0);
        repeat (2) step();
        S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        step();
        S_AXI_WVALID = 1'b0;
        check("late_w_bvalid_early", 32'(S_AXI_BVALID), 32'd0);
        step();
        check("late_w_bvalid", 32'(S_AXI_BVALID), 32'd1);
        check("late_w_bresp",  32'(S_AXI_BRESP), 32'd0);
        check("late_w_ctrl0",  ctrl_o[31:0], 32'h1);
        step();
        check("late_w_bvalid_drop", 32'(S_AXI_BVALID), 32'd0);
        S_AXI_BREADY = 1'b0;

        for (int i = 0; i < 10; i++) begin
            axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, resp, cap);
            check($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].bresp));
            axi_read(vecs[i].raddr, rd, resp);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("vec%0d_rresp", i), 32'(resp), 32'(vecs[i].rresp));
        end
        check("tbl_ctrl0", ctrl_o[31:0],   32'h00000001);
        check("tbl_ctrl1", ctrl_o[63:32],  32'hAABB11DD);
        check("tbl_ctrl2", ctrl_o[95:64],  32'hCA00000D);
        check("tbl_ctrl3", ctrl_o[127:96], 32'h12345678);

        // snapshot capture
        ch_count_i = {32'h00003333, 32'h00001234, 32'h00000111, 32'h00000ABC};
        axi_write(8'h00, 32'h2, 4'hF, resp, cap);
        check("cap_pulse", 32'(cap), 32'd1);
        check("cap_pulse_end", 32'(capture_o), 32'd0);
        ch_count_i = '1;
        axi_read(8'h20, rd, resp);
        check("cap_ch2", rd, 32'h00001234);
        axi_read(8'h18, rd, resp);
        check("cap_ch0", rd, 32'h00000ABC);
        axi_read(8'h24, rd, resp);
        check("cap_ch3", rd, 32'h00003333);
        axi_read(8'h00, rd, resp);
        check("cap_ctrl0_clear", rd, 32'h0);
        ch_count_i[95:64] = 32'h00005678;
        write_at_commit(8'h00, 32'h2, 1'b1, 8'h20, 4'b0, rd);
        check("cap_read_same_cycle", rd, 32'h00001234);
        axi_read(8'h20, rd, resp);
        check("cap_ch2_new", rd, 32'h00005678);

        // read and write of one register on the same edge
        write_at_commit(8'h0C, 32'hA5A5A5A5, 1'b1, 8'h0C, 4'b0, rd);
        check("rw_same_old", rd, 32'h12345678);
        axi_read(8'h0C, rd, resp);
        check("rw_same_new", rd, 32'hA5A5A5A5);

        // interrupts
        axi_write(8'h14, 32'h1, 4'hF, resp, cap);
        step();
        ch_done_i = 4'b0001;
        step();
        ch_done_i = 4'b0;
        step();
        check("irq_set", 32'(irq_o), 32'd1);
        axi_read(8'h10, rd, resp);
        check("irq_status", rd, 32'h1);
        write_at_commit(8'h10, 32'h1, 1'b0, 8'h00, 4'b0001, rd);
        axi_read(8'h10, rd, resp);
        check("w1c_set_wins", rd, 32'h1);
        axi_write(8'h10, 32'h1, 4'hF, resp, cap);
        axi_read(8'h10, rd, resp);
        check("w1c_cleared", rd, 32'h0);
        check("irq_cleared", 32'(irq_o), 32'd0);
        ch_done_i = 4'b0100;
        step();
        ch_done_i = 4'b0;
        axi_read(8'h10, rd, resp);
        check("status_ch2", rd, 32'h4);
        check("irq_masked", 32'(irq_o), 32'd0);

        // response backpressure, second write parked, then reset
        S_AXI_AWADDR = 8'h04; S_AXI_WDATA = 32'h11111111; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        step();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        step();
        check("bp_first_bvalid", 32'(S_AXI_BVALID), 32'd1);
        S_AXI_AWADDR = 8'h08; S_AXI_WDATA = 32'h22222222;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 8'h04; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        step();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        repeat (10) step();
        check("bp_awready", 32'(S_AXI_AWREADY), 32'd0);
        check("bp_wready",  32'(S_AXI_WREADY),  32'd0);
        check("bp_bvalid",  32'(S_AXI_BVALID),  32'd1);
        check("bp_rvalid",  32'(S_AXI_RVALID),  32'd1);
        check("bp_rdata",   S_AXI_RDATA, 32'h11111111);
        check("bp_ctrl1",   ctrl_o[63:32], 32'h11111111);
        check("bp_ctrl2_unchanged", ctrl_o[95:64], 32'hCA00000D);
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        check("mid_rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
        check("mid_rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
        check("mid_rst_ready",   32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'h7);
        check("mid_rst_ctrl_o",  32'(ctrl_o == '0), 32'd1);
        repeat (5) step();
        check("mid_rst_no_late_b", 32'(S_AXI_BVALID), 32'd0);
        check("mid_rst_ctrl2", ctrl_o[95:64], 32'h0);
        axi_read(8'h10, rd, resp);
        check("mid_rst_status", rd, 32'h0);
        axi_read(8'h14, rd, resp);
        check("mid_rst_enable", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
